// File: rtl/vx_prefetch_pkg.sv
// Shared types and throttle thresholds for the per-bank next-line prefetch issuer.
// The threshold decision is a pure function so the throttle stays a thin register wrapper.
package vx_prefetch_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } pf_state_e;

   typedef enum logic [1:0] {
      THR_HOLD = 2'd0,
      THR_UP   = 2'd1,
      THR_DOWN = 2'd2
   } thr_action_e;

   // Usefulness ratio thresholds: raise at >= 3/4 used, lower below 1/4 used.
   localparam int unsigned THR_DEN      = 32'd4;
   localparam int unsigned THR_UP_NUM   = 32'd3;
   localparam int unsigned THR_DOWN_NUM = 32'd1;

   function automatic thr_action_e thr_decide(input int unsigned use_cnt,
                                              input int unsigned window);
      thr_action_e act;
      if (use_cnt * THR_DEN >= window * THR_UP_NUM) begin
         act = THR_UP;
      end else if (use_cnt * THR_DEN < window * THR_DOWN_NUM) begin
         act = THR_DOWN;
      end else begin
         act = THR_HOLD;
      end
      return act;
   endfunction

endpackage

// File: rtl/vx_prefetch_throttle.sv
// Adaptive burst-degree controller: counts used-bit feedback over fixed windows
// and nudges the prefetch degree up or down by one at each window boundary.
module vx_prefetch_throttle
   import vx_prefetch_pkg::*;
#(
   parameter int unsigned MAX_DEGREE  = 4,
   parameter int unsigned MIN_DEGREE  = 1,
   parameter int unsigned INIT_DEGREE = 2,
   parameter int unsigned WINDOW      = 64,
   localparam int unsigned DEG_W      = $clog2(MAX_DEGREE + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fb_valid,
   input  logic             fb_used,
   output logic [DEG_W-1:0] degree
);

   localparam int unsigned CNT_W = $clog2(WINDOW) + 1;

   logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] use_cnt_q, use_cnt_d;
   logic [DEG_W-1:0] degree_q, degree_d;
   logic [CNT_W-1:0] win_inc_s;
   logic [CNT_W-1:0] use_inc_s;

   // Window accounting; the closing event is counted before the decision is taken.
   always_comb begin
      win_cnt_d = win_cnt_q;
      use_cnt_d = use_cnt_q;
      degree_d  = degree_q;
      win_inc_s = win_cnt_q + CNT_W'(1);
      use_inc_s = use_cnt_q + CNT_W'(fb_used);
      if (fb_valid) begin
         if (win_inc_s == CNT_W'(WINDOW)) begin
            win_cnt_d = '0;
            use_cnt_d = '0;
            case (thr_decide(32'(use_inc_s), WINDOW))
               THR_UP: begin
                  if (degree_q < DEG_W'(MAX_DEGREE)) begin
                     degree_d = degree_q + DEG_W'(1);
                  end else begin
                     degree_d = degree_q;
                  end
               end
               THR_DOWN: begin
                  if (degree_q > DEG_W'(MIN_DEGREE)) begin
                     degree_d = degree_q - DEG_W'(1);
                  end else begin
                     degree_d = degree_q;
                  end
               end
               default: degree_d = degree_q;
            endcase
         end else begin
            win_cnt_d = win_inc_s;
            use_cnt_d = use_inc_s;
         end
      end else begin
         win_cnt_d = win_cnt_q;
         use_cnt_d = use_cnt_q;
      end
   end

   // Throttle state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_cnt_q <= '0;
         use_cnt_q <= '0;
         degree_q  <= DEG_W'(INIT_DEGREE);
      end else begin
         win_cnt_q <= win_cnt_d;
         use_cnt_q <= use_cnt_d;
         degree_q  <= degree_d;
      end
   end

   assign degree = degree_q;

endmodule

// File: rtl/vx_prefetch_issuer.sv
// Next-line prefetch issuer: on an accepted demand-miss trigger, emits a burst of
// sequential line prefetches whose length is the throttle degree at acceptance time.
module vx_prefetch_issuer
   import vx_prefetch_pkg::*;
#(
   parameter int unsigned LINE_ADDR_WIDTH = 26,
   parameter int unsigned MAX_DEGREE      = 4,
   parameter int unsigned MIN_DEGREE      = 1,
   parameter int unsigned INIT_DEGREE     = 2,
   parameter int unsigned WINDOW          = 64,
   localparam int unsigned DEG_W          = $clog2(MAX_DEGREE + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       trig_valid,
   input  logic [LINE_ADDR_WIDTH-1:0] trig_addr,
   output logic                       trig_ready,
   output logic                       pf_valid,
   output logic [LINE_ADDR_WIDTH-1:0] pf_addr,
   output logic                       pf_prefetch,
   input  logic                       pf_ready,
   input  logic                       fb_valid,
   input  logic                       fb_used,
   output logic [DEG_W-1:0]           degree,
   output logic [31:0]                perf_pf_issued
);

   pf_state_e                  state_q, state_d;
   logic [LINE_ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic [DEG_W-1:0]           remaining_q, remaining_d;
   logic [31:0]                perf_q, perf_d;
   logic [DEG_W-1:0]           degree_s;
   logic                       trig_ready_s;

   vx_prefetch_throttle #(
      .MAX_DEGREE  (MAX_DEGREE),
      .MIN_DEGREE  (MIN_DEGREE),
      .INIT_DEGREE (INIT_DEGREE),
      .WINDOW      (WINDOW)
   ) u_throttle (
      .clk      (clk),
      .reset    (reset),
      .fb_valid (fb_valid),
      .fb_used  (fb_used),
      .degree   (degree_s)
   );

   // Burst FSM; the degree sampled here is the registered (pre-update) value.
   always_comb begin
      state_d      = state_q;
      next_addr_d  = next_addr_q;
      remaining_d  = remaining_q;
      perf_d       = perf_q;
      trig_ready_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            trig_ready_s = 1'b1;
            if (trig_valid) begin
               next_addr_d = trig_addr + LINE_ADDR_WIDTH'(1);
               remaining_d = degree_s;
               state_d     = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (pf_ready) begin
               next_addr_d = next_addr_q + LINE_ADDR_WIDTH'(1);
               remaining_d = remaining_q - DEG_W'(1);
               perf_d      = perf_q + 32'd1;
               if (remaining_q == DEG_W'(1)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         next_addr_q <= '0;
         remaining_q <= '0;
         perf_q      <= '0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         remaining_q <= remaining_d;
         perf_q      <= perf_d;
      end
   end

   assign trig_ready     = trig_ready_s & ~reset;
   assign pf_valid       = (state_q == ST_ISSUE);
   assign pf_prefetch    = (state_q == ST_ISSUE);
   assign pf_addr        = next_addr_q;
   assign degree         = degree_s;
   assign perf_pf_issued = perf_q;

endmodule

// File: tb/tb_vx_prefetch_issuer.sv
// Self-checking bench: a queue-based model of pending prefetch lines and a
// window/ratio model of the throttle predict every observed output.
module tb_vx_prefetch_issuer;

   localparam int AW = 26;
   localparam int DW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          trig_valid;
   logic [AW-1:0] trig_addr;
   logic          trig_ready;
   logic          pf_valid;
   logic [AW-1:0] pf_addr;
   logic          pf_prefetch;
   logic          pf_ready;
   logic          fb_valid;
   logic          fb_used;
   logic [DW-1:0] degree;
   logic [31:0]   perf_pf_issued;

   always #5 clk = ~clk;

   vx_prefetch_issuer dut (
      .clk            (clk),
      .reset          (reset),
      .trig_valid     (trig_valid),
      .trig_addr      (trig_addr),
      .trig_ready     (trig_ready),
      .pf_valid       (pf_valid),
      .pf_addr        (pf_addr),
      .pf_prefetch    (pf_prefetch),
      .pf_ready       (pf_ready),
      .fb_valid       (fb_valid),
      .fb_used        (fb_used),
      .degree         (degree),
      .perf_pf_issued (perf_pf_issued)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: outstanding prefetch lines plus throttle bookkeeping.
   logic [AW-1:0] pend[$];
   int            m_deg;
   int            m_win;
   int            m_use;
   logic [31:0]   m_perf;

   task automatic model_reset();
      pend.delete();
      m_deg  = 2;
      m_win  = 0;
      m_use  = 0;
      m_perf = 32'd0;
   endtask

   // Advance the model by the current inputs, then move to just after the next edge.
   task automatic tick();
      if (pend.size() == 0) begin
         if (trig_valid) begin
            for (int i = 1; i <= m_deg; i++) pend.push_back(trig_addr + AW'(i));
         end
      end else if (pf_ready) begin
         void'(pend.pop_front());
         m_perf = m_perf + 32'd1;
      end
      if (fb_valid) begin
         m_win++;
         if (fb_used) m_use++;
         if (m_win == 64) begin
            if (m_use * 4 >= 64 * 3) m_deg = (m_deg < 4) ? m_deg + 1 : 4;
            else if (m_use * 4 < 64) m_deg = (m_deg > 1) ? m_deg - 1 : 1;
            m_win = 0;
            m_use = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      trig_valid = 1'b0;
      trig_addr  = '0;
      fb_valid   = 1'b0;
      fb_used    = 1'b0;
      pf_ready   = 1'b1;
   endtask

   task automatic send_fb(input int n, input int nused);
      int need = nused;
      for (int k = 0; k < n; k++) begin
         fb_valid = 1'b1;
         fb_used  = ($urandom_range(n - k - 1, 0) < need);
         if (fb_used) need--;
         tick();
      end
      fb_valid = 1'b0;
      fb_used  = 1'b0;
   endtask

   task automatic test_reset();
      quiet_inputs();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (pf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pf_valid: got %b want 0", pf_valid); end
      n_checks++; if (trig_ready !== 1'b0) begin n_fail++; $display("FAIL reset_trig_ready: got %b want 0", trig_ready); end
      n_checks++; if (pf_addr !== '0) begin n_fail++; $display("FAIL reset_pf_addr: got %h want 0", pf_addr); end
      n_checks++; if (degree !== 3'd2) begin n_fail++; $display("FAIL reset_degree: got %0d want 2", degree); end
      n_checks++; if (perf_pf_issued !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d want 0", perf_pf_issued); end
      reset = 1'b0;
      tick();
      n_checks++; if (trig_ready !== 1'b1) begin n_fail++; $display("FAIL idle_trig_ready: got %b want 1", trig_ready); end
   endtask

   task automatic test_basic();
      trig_valid = 1'b1;
      trig_addr  = 26'h100;
      tick();
      trig_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (pf_valid !== (pend.size() != 0)) begin n_fail++; $display("FAIL basic_valid c%0d: got %b want %b", c, pf_valid, pend.size() != 0); end
         n_checks++; if (pf_prefetch !== pf_valid) begin n_fail++; $display("FAIL basic_prefetch c%0d: got %b want %b", c, pf_prefetch, pf_valid); end
         if (pend.size() != 0) begin
            n_checks++; if (pf_addr !== pend[0]) begin n_fail++; $display("FAIL basic_addr c%0d: got %h want %h", c, pf_addr, pend[0]); end
         end
         tick();
      end
      n_checks++; if (perf_pf_issued !== 32'd2) begin n_fail++; $display("FAIL basic_perf: got %0d want 2", perf_pf_issued); end
      n_checks++; if (degree !== 3'd2) begin n_fail++; $display("FAIL basic_degree: got %0d want 2", degree); end
      n_checks++; if (trig_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got %b want 1", trig_ready); end
   endtask

   task automatic test_backpressure();
      trig_valid = 1'b1;
      trig_addr  = 26'h200;
      pf_ready   = 1'b0;
      tick();
      trig_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_checks++; if (pf_valid !== 1'b1 || pf_addr !== 26'h201) begin n_fail++; $display("FAIL bp_hold c%0d: got %b/%h want 1/201", c, pf_valid, pf_addr); end
         tick();
      end
      pf_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (pf_valid !== (pend.size() != 0)) begin n_fail++; $display("FAIL bp_valid c%0d: got %b want %b", c, pf_valid, pend.size() != 0); end
         if (pend.size() != 0) begin
            n_checks++; if (pf_addr !== pend[0]) begin n_fail++; $display("FAIL bp_addr c%0d: got %h want %h", c, pf_addr, pend[0]); end
         end
         tick();
      end
      n_checks++; if (perf_pf_issued !== 32'd4) begin n_fail++; $display("FAIL bp_perf: got %0d want 4", perf_pf_issued); end
   endtask

   task automatic test_wrap();
      trig_valid = 1'b1;
      trig_addr  = {AW{1'b1}};
      tick();
      trig_valid = 1'b0;
      n_checks++; if (pf_valid !== 1'b1 || pf_addr !== 26'h0) begin n_fail++; $display("FAIL wrap_first: got %b/%h want 1/0", pf_valid, pf_addr); end
      tick();
      n_checks++; if (pf_valid !== 1'b1 || pf_addr !== 26'h1) begin n_fail++; $display("FAIL wrap_second: got %b/%h want 1/1", pf_valid, pf_addr); end
      tick();
      n_checks++; if (pf_valid !== 1'b0 || trig_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_end: got %b/%b want 0/1", pf_valid, trig_ready); end
   endtask

   task automatic test_drop();
      trig_valid = 1'b1;
      trig_addr  = 26'h300;
      tick();
      trig_addr  = 26'h500;
      n_checks++; if (trig_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b want 0", trig_ready); end
      tick();
      trig_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (pf_valid !== (pend.size() != 0)) begin n_fail++; $display("FAIL drop_valid c%0d: got %b want %b", c, pf_valid, pend.size() != 0); end
         if (pend.size() != 0) begin
            n_checks++; if (pf_addr !== pend[0]) begin n_fail++; $display("FAIL drop_addr c%0d: got %h want %h", c, pf_addr, pend[0]); end
         end
         tick();
      end
      n_checks++; if (perf_pf_issued !== m_perf) begin n_fail++; $display("FAIL drop_perf: got %0d want %0d", perf_pf_issued, m_perf); end
   endtask

   task automatic test_throttle();
      int used_tab[10] = '{48, 48, 64, 15, 16, 15, 0, 10, 47, 48};
      int deg_tab[10]  = '{3, 4, 4, 3, 3, 2, 1, 1, 1, 2};
      for (int w = 0; w < 10; w++) begin
         int need = used_tab[w];
         int d0   = m_deg;
         for (int k = 0; k < 64; k++) begin
            fb_valid = 1'b1;
            fb_used  = ($urandom_range(63 - k, 0) < need);
            if (fb_used) need--;
            if (k == 63) begin
               n_checks++; if (degree !== 3'(d0)) begin n_fail++; $display("FAIL thr_early w%0d: got %0d want %0d", w, degree, d0); end
            end
            tick();
         end
         fb_valid = 1'b0;
         n_checks++; if (degree !== 3'(deg_tab[w]) || degree !== 3'(m_deg)) begin n_fail++; $display("FAIL thr_degree w%0d: got %0d want %0d", w, degree, deg_tab[w]); end
      end
   endtask

   task automatic test_collision();
      int d0;
      int burst;
      send_fb(63, 63);
      d0 = m_deg;
      fb_valid   = 1'b1;
      fb_used    = 1'b1;
      trig_valid = 1'b1;
      trig_addr  = 26'h0ABCDE;
      tick();
      fb_valid   = 1'b0;
      trig_valid = 1'b0;
      n_checks++; if (degree !== 3'(m_deg)) begin n_fail++; $display("FAIL coll_degree: got %0d want %0d", degree, m_deg); end
      burst = 0;
      for (int c = 0; c < 8; c++) begin
         if (pf_valid === 1'b1) burst++;
         n_checks++; if (pf_valid !== (pend.size() != 0)) begin n_fail++; $display("FAIL coll_valid c%0d: got %b want %b", c, pf_valid, pend.size() != 0); end
         tick();
      end
      n_checks++; if (burst != d0) begin n_fail++; $display("FAIL coll_burst_len: got %0d want %0d", burst, d0); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         trig_valid = ($urandom_range(9, 0) < 3);
         trig_addr  = AW'($urandom);
         pf_ready   = ($urandom_range(9, 0) < 6);
         fb_valid   = $urandom_range(1, 0);
         fb_used    = (c < 200) ? ($urandom_range(9, 0) < 9) : ($urandom_range(9, 0) < 1);
         n_checks++; if (pf_valid !== (pend.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, pf_valid, pend.size() != 0); end
         n_checks++; if (trig_ready !== (pend.size() == 0)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, trig_ready, pend.size() == 0); end
         if (pend.size() != 0) begin
            n_checks++; if (pf_addr !== pend[0]) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, pf_addr, pend[0]); end
         end
         n_checks++; if (degree !== 3'(m_deg)) begin n_fail++; $display("FAIL rnd_degree c%0d: got %0d want %0d", c, degree, m_deg); end
         n_checks++; if (perf_pf_issued !== m_perf) begin n_fail++; $display("FAIL rnd_perf c%0d: got %0d want %0d", c, perf_pf_issued, m_perf); end
         tick();
      end
      quiet_inputs();
      repeat (6) tick();
   endtask

   task automatic test_async_reset();
      send_fb(130, 130);
      send_fb(30, 30);
      n_checks++; if (degree !== 3'(m_deg)) begin n_fail++; $display("FAIL ar_pre_degree: got %0d want %0d", degree, m_deg); end
      trig_valid = 1'b1;
      trig_addr  = 26'h700;
      pf_ready   = 1'b0;
      tick();
      trig_valid = 1'b0;
      tick();
      n_checks++; if (pf_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b want 1", pf_valid); end
      #1;
      reset = 1'b1;
      #1;
      n_checks++; if (pf_valid !== 1'b0) begin n_fail++; $display("FAIL ar_async_valid: got %b want 0", pf_valid); end
      n_checks++; if (trig_ready !== 1'b0) begin n_fail++; $display("FAIL ar_trig_ready: got %b want 0", trig_ready); end
      model_reset();
      @(posedge clk);
      #1;
      reset    = 1'b0;
      pf_ready = 1'b1;
      n_checks++; if (degree !== 3'd2 || perf_pf_issued !== 32'd0) begin n_fail++; $display("FAIL ar_post: got %0d/%0d want 2/0", degree, perf_pf_issued); end
      send_fb(34, 34);
      n_checks++; if (degree !== 3'd2) begin n_fail++; $display("FAIL ar_counters_cleared: got %0d want 2", degree); end
      test_basic();
   endtask

   initial begin
      reset = 1'b1;
      quiet_inputs();
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_drop();
      test_throttle();
      test_collision();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
